// File: rtl/booth_calc_pkg.sv
// Shared types and helpers for the Booth calculator display path.
package booth_calc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  typedef logic [3:0] digit_t;

  localparam int unsigned DIGITS_DEF = 5;
  localparam int unsigned BCD_W      = 4 * DIGITS_DEF;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import booth_calc_pkg::*;
(
  input  digit_t raw,
  output digit_t adj
);

  assign adj = (raw >= 4'd5) ? raw + 4'd3 : raw;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential signed-binary to BCD converter (shift-and-add-3) with start/done handshake
// and double-buffered display outputs.
module result_bcd_converter
  import booth_calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (pow10(DIGITS) <= (64'd1 << (WIDTH - 1))) begin : g_digits_too_few
    $error("result_bcd_converter: DIGITS too small for WIDTH");
  end

  state_t           state_q, state_d;
  logic             req_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    scr_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q;
  logic [BW-1:0]    bcd_q;
  logic             neg_q;
  logic [DIGITS-1:0] en_q;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [WIDTH-1:0]  mag_load;
  logic [DIGITS-1:0] en_nx;
  logic              any_nz;
  logic              capture;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .raw (scr_q[4*i +: 4]),
      .adj (adj[4*i +: 4])
    );
  end

  assign shifted  = {adj[BW-2:0], mag_q[WIDTH-1]};
  assign mag_load = res_q[WIDTH-1] ? (~res_q + WIDTH'(1)) : res_q;

  // start is registered; only a fresh request seen in IDLE launches a conversion.
  assign capture = (state_q == IDLE) && start && !req_q;

  always_comb begin
    en_nx  = '0;
    any_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz   = any_nz | (shifted[4*i +: 4] != 4'd0);
      en_nx[i] = any_nz;
    end
    en_nx[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_q) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      res_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      en_q    <= DIGITS'(1);
    end else begin
      state_q <= state_d;
      req_q   <= capture;
      if (capture) begin
        res_q <= result;
      end
      unique case (state_q)
        LOAD: begin
          mag_q  <= mag_load;
          sign_q <= res_q[WIDTH-1];
          scr_q  <= '0;
          cnt_q  <= CW'(WIDTH);
        end
        SHIFT: begin
          scr_q <= shifted;
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q <= shifted;
            // A zero magnitude never displays as "-0".
            neg_q <= sign_q & (|shifted);
            en_q  <= en_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == LOAD) || (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign negative = neg_q;
  assign bcd      = bcd_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed, table-driven bench for result_bcd_converter (WIDTH=16, DIGITS=5).
module tb_result_bcd_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        negative;
  logic [19:0] bcd;
  logic [4:0]  digit_en;

  int errors = 0;
  int checks = 0;
  int ovl    = 0;

  result_bcd_converter #(
    .WIDTH  (16),
    .DIGITS (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .negative (negative),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [19:0] bcd;
    logic        neg;
    logic [4:0]  en;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy && done) ovl++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch a conversion; lat = edges from the start edge until done seen (-1 on timeout).
  task automatic convert(input logic [15:0] r, output int lat, output int bsy);
    result = r;
    start  = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    bsy = busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (busy) bsy++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, bsy, dcount;

  initial begin
    vecs[0] = '{16'h0000, 20'h00000, 1'b0, 5'b00001};
    vecs[1] = '{16'h2B67, 20'h11111, 1'b0, 5'b11111};
    vecs[2] = '{16'hFFFF, 20'h00001, 1'b1, 5'b00001};
    vecs[3] = '{16'h8000, 20'h32768, 1'b1, 5'b11111};
    vecs[4] = '{16'h4000, 20'h16384, 1'b0, 5'b11111};
    vecs[5] = '{16'h00FF, 20'h00255, 1'b0, 5'b00111};
    vecs[6] = '{16'h7FFF, 20'h32767, 1'b0, 5'b11111};
    vecs[7] = '{16'hFF9C, 20'h00100, 1'b1, 5'b00111};
    vecs[8] = '{16'h000A, 20'h00010, 1'b0, 5'b00011};
    vecs[9] = '{16'hD8F1, 20'h09999, 1'b1, 5'b01111};

    rst    = 1'b1;
    start  = 1'b0;
    result = 16'h0000;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset neg", 32'(negative), 32'd0);
    chk("reset bcd", 32'(bcd), 32'h0);
    chk("reset en", 32'(digit_en), 32'h1);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 10; v++) begin
      convert(vecs[v].res, lat, bsy);
      chk($sformatf("latency[%0d]", v), 32'(lat), 32'd18);
      chk($sformatf("busy cycles[%0d]", v), 32'(bsy), 32'd17);
      chk($sformatf("bcd[%0d]", v), 32'(bcd), 32'(vecs[v].bcd));
      chk($sformatf("neg[%0d]", v), 32'(negative), 32'(vecs[v].neg));
      chk($sformatf("en[%0d]", v), 32'(digit_en), 32'(vecs[v].en));
      tick();
      chk($sformatf("done pulse[%0d]", v), 32'(done), 32'd0);
      tick();
    end

    // Outputs hold the previous result while a new conversion runs.
    convert(16'h8000, lat, bsy);
    chk("hold first bcd", 32'(bcd), 32'h32768);
    tick();
    result = 16'h4000;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("hold mid busy", 32'(busy), 32'd1);
    chk("hold mid bcd", 32'(bcd), 32'h32768);
    chk("hold mid neg", 32'(negative), 32'd1);
    lat = -1;
    for (int n = 11; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (bcd !== 20'h32768) lat = -2;
    end
    chk("hold latency", 32'(lat), 32'd18);
    chk("hold second bcd", 32'(bcd), 32'h16384);
    chk("hold second neg", 32'(negative), 32'd0);
    tick();
    tick();

    // Start pulses mid-conversion are ignored.
    result = 16'h00FF;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    result = 16'h1234;
    dcount = 0;
    for (int n = 1; n <= 45; n++) begin
      start = (n == 5 || n == 10) ? 1'b1 : 1'b0;
      tick();
      if (done) dcount++;
    end
    start = 1'b0;
    chk("ignored start dones", 32'(dcount), 32'd1);
    chk("ignored start busy", 32'(busy), 32'd0);
    chk("ignored start bcd", 32'(bcd), 32'h00255);
    chk("ignored start en", 32'(digit_en), 32'h07);

    // Held start re-triggers after DONE.
    convert(16'h0001, lat, bsy);
    start = 1'b1;
    tick();
    start = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    chk("held start retrigger", 32'(busy), 32'd1);
    start = 1'b0;
    for (int n = 0; n < 25; n++) tick();
    chk("retrigger idle", 32'(busy), 32'd0);

    // Reset mid-SHIFT aborts the conversion.
    convert(16'h2B67, lat, bsy);
    tick();
    result = 16'h04D2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("pre-abort busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort bcd", 32'(bcd), 32'h0);
    chk("abort en", 32'(digit_en), 32'h1);
    tick();
    rst = 1'b0;
    dcount = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (done) dcount++;
    end
    chk("abort no done", 32'(dcount), 32'd0);
    convert(16'h04D2, lat, bsy);
    chk("post-abort latency", 32'(lat), 32'd18);
    chk("post-abort bcd", 32'(bcd), 32'h01234);
    chk("post-abort en", 32'(digit_en), 32'h0F);

    chk("busy/done overlap", 32'(ovl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
